// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage : execute stage of the MiniMIPS32 five-stage pipeline.
//
// Computes the write-back value (or memory address) for the instruction held in
// the ID/EXE register, the {HI,LO} update for MULT/DIV, and requests a pipeline
// stall while a multi-cycle signed division is running.
//
// Ports
//   cpu_clk_50M, cpu_rst_n     : clock, asynchronous active-low reset
//   exe_alutype_i/exe_aluop_i  : operation class / opcode from decode
//   exe_src1_i/exe_src2_i      : operands (src1 is the shift amount for SLL)
//   exe_wa_i/wreg/mreg/whilo   : destination and write-enable controls
//   exe_din_i, exe_retaddr_i   : store data, link address (PC+8)
//   hi_i/lo_i                  : architectural HI/LO
//   mem2exe_*/wb2exe_*         : in-flight HI/LO writes for forwarding
//   exe_*_o                    : results and passthroughs to MEM (and decode)
//   stallreq_exe               : stall request while DIV is busy
//
// Handshake: stallreq_exe=1 means "hold the ID/EXE inputs stable"; the stage
// consumes an instruction in any cycle where stallreq_exe=0.
//
// All outputs are combinational and forced to 0 while cpu_rst_n is low.
// -----------------------------------------------------------------------------
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [2:0]  exe_alutype_i,
  input  logic [7:0]  exe_aluop_i,
  input  logic [31:0] exe_src1_i,
  input  logic [31:0] exe_src2_i,
  input  logic [4:0]  exe_wa_i,
  input  logic        exe_wreg_i,
  input  logic        exe_mreg_i,
  input  logic        exe_whilo_i,
  input  logic [31:0] exe_din_i,
  input  logic [31:0] exe_retaddr_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem2exe_whilo,
  input  logic [63:0] mem2exe_hilo,
  input  logic        wb2exe_whilo,
  input  logic [63:0] wb2exe_hilo,
  output logic [7:0]  exe_aluop_o,
  output logic [4:0]  exe_wa_o,
  output logic        exe_wreg_o,
  output logic        exe_mreg_o,
  output logic [31:0] exe_wd_o,
  output logic [31:0] exe_din_o,
  output logic        exe_whilo_o,
  output logic [63:0] exe_hilo_o,
  output logic        stallreq_exe
);

  // Operation classes
  localparam logic [2:0] T_ARITH = 3'd1;
  localparam logic [2:0] T_LOGIC = 3'd2;
  localparam logic [2:0] T_MOVE  = 3'd3;
  localparam logic [2:0] T_SHIFT = 3'd4;
  localparam logic [2:0] T_JUMP  = 3'd5;

  // Opcodes
  localparam logic [7:0] OP_ADD   = 8'h18;
  localparam logic [7:0] OP_ADDIU = 8'h19;
  localparam logic [7:0] OP_SUBU  = 8'h1B;
  localparam logic [7:0] OP_AND   = 8'h1C;
  localparam logic [7:0] OP_ORI   = 8'h1D;
  localparam logic [7:0] OP_SLT   = 8'h26;
  localparam logic [7:0] OP_SLTIU = 8'h27;
  localparam logic [7:0] OP_MULT  = 8'h14;
  localparam logic [7:0] OP_DIV   = 8'h16;
  localparam logic [7:0] OP_MFHI  = 8'h0C;
  localparam logic [7:0] OP_MFLO  = 8'h0D;
  localparam logic [7:0] OP_SLL   = 8'h11;
  localparam logic [7:0] OP_LUI   = 8'h05;
  localparam logic [7:0] OP_LB    = 8'h90;
  localparam logic [7:0] OP_LW    = 8'h92;
  localparam logic [7:0] OP_SB    = 8'h98;
  localparam logic [7:0] OP_SW    = 8'h9A;

  localparam int CW = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // ---------------------------------------------------------------------------
  // Divider state and datapath registers
  // ---------------------------------------------------------------------------
  div_state_t    r_state;
  div_state_t    w_next_state;
  logic [31:0]   r_rem;      // partial remainder (magnitude)
  logic [31:0]   r_quo;      // dividend bits shift out the top, quotient bits shift in
  logic [31:0]   r_divisor;  // |divisor|
  logic          r_q_neg;    // quotient must be negated at the end
  logic          r_r_neg;    // remainder takes the dividend's sign
  logic [CW-1:0] r_cnt;

  logic          w_is_div;
  logic          w_div_start;
  logic          w_div_zero;
  logic          w_div_step;
  logic          w_div_done;
  logic          w_div_stall;

  assign w_is_div = (exe_aluop_i == OP_DIV);

  // FSM state register
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and control
  always_comb begin
    w_next_state = r_state;
    w_div_start  = 1'b0;
    w_div_zero   = 1'b0;
    w_div_step   = 1'b0;
    w_div_done   = 1'b0;
    w_div_stall  = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (w_is_div) begin
          w_div_stall = 1'b1;
          if (exe_src2_i == 32'd0) begin
            w_div_zero   = 1'b1;
            w_next_state = DIV_DONE;
          end else begin
            w_div_start  = 1'b1;
            w_next_state = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (!w_is_div) begin
          // Instruction replaced under us (flush): drop the division.
          w_next_state = DIV_IDLE;
        end else begin
          w_div_stall = 1'b1;
          w_div_step  = 1'b1;
          if (r_cnt == CW'(DIV_CYCLES - 1)) begin
            w_next_state = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        w_div_done   = w_is_div;
        w_next_state = DIV_IDLE;
      end
      default: begin
        w_next_state = DIV_IDLE;
      end
    endcase
  end

  // Operand magnitudes; 0x80000000 maps to itself, which is the right unsigned value.
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  assign w_abs1 = exe_src1_i[31] ? (32'd0 - exe_src1_i) : exe_src1_i;
  assign w_abs2 = exe_src2_i[31] ? (32'd0 - exe_src2_i) : exe_src2_i;

  // One restoring step: bring down the next dividend bit and try a subtract.
  logic [32:0] w_partial;
  logic        w_fits;
  logic [31:0] w_diff;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  assign w_partial  = {r_rem, r_quo[31]};
  assign w_fits     = (w_partial >= {1'b0, r_divisor});
  // When the subtract fits, the difference is below the divisor, so 32 bits hold it.
  assign w_diff     = w_partial[31:0] - r_divisor;
  assign w_rem_next = w_fits ? w_diff : w_partial[31:0];
  assign w_quo_next = {r_quo[30:0], w_fits};

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_div_start) begin
      r_rem     <= '0;
      r_quo     <= w_abs1;
      r_divisor <= w_abs2;
      r_q_neg   <= exe_src1_i[31] ^ exe_src2_i[31];
      r_r_neg   <= exe_src1_i[31];
      r_cnt     <= '0;
    end else if (w_div_zero) begin
      // Divide by zero: preload the fixed result so DONE needs no special case.
      r_rem     <= exe_src1_i;
      r_quo     <= 32'hFFFF_FFFF;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_div_step) begin
      r_rem     <= w_rem_next;
      r_quo     <= w_quo_next;
      r_cnt     <= r_cnt + CW'(1);
    end
  end

  logic [31:0] w_div_lo;
  logic [31:0] w_div_hi;
  assign w_div_lo = r_q_neg ? (32'd0 - r_quo) : r_quo;
  assign w_div_hi = r_r_neg ? (32'd0 - r_rem) : r_rem;

  // ---------------------------------------------------------------------------
  // Single-cycle signed multiply
  // ---------------------------------------------------------------------------
  logic signed [63:0] w_prod;
  assign w_prod = $signed(exe_src1_i) * $signed(exe_src2_i);

  // ---------------------------------------------------------------------------
  // HI/LO forwarding: youngest in-flight writer wins
  // ---------------------------------------------------------------------------
  logic [31:0] w_hi_fwd;
  logic [31:0] w_lo_fwd;

  always_comb begin
    w_hi_fwd = hi_i;
    w_lo_fwd = lo_i;
    if (mem2exe_whilo) begin
      w_hi_fwd = mem2exe_hilo[63:32];
      w_lo_fwd = mem2exe_hilo[31:0];
    end else if (wb2exe_whilo) begin
      w_hi_fwd = wb2exe_hilo[63:32];
      w_lo_fwd = wb2exe_hilo[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back value / effective address
  // ---------------------------------------------------------------------------
  logic [31:0] w_wd;

  always_comb begin
    w_wd = '0;
    case (exe_alutype_i)
      T_ARITH: begin
        case (exe_aluop_i)
          OP_ADD, OP_ADDIU, OP_LB, OP_LW, OP_SB, OP_SW:
            w_wd = exe_src1_i + exe_src2_i;
          OP_SUBU:  w_wd = exe_src1_i - exe_src2_i;
          OP_SLT:   w_wd = {31'd0, ($signed(exe_src1_i) < $signed(exe_src2_i))};
          OP_SLTIU: w_wd = {31'd0, (exe_src1_i < exe_src2_i)};
          default:  w_wd = '0;
        endcase
      end
      T_LOGIC: begin
        case (exe_aluop_i)
          OP_AND:  w_wd = exe_src1_i & exe_src2_i;
          OP_ORI:  w_wd = exe_src1_i | exe_src2_i;
          OP_LUI:  w_wd = exe_src2_i;
          default: w_wd = '0;
        endcase
      end
      T_MOVE: begin
        case (exe_aluop_i)
          OP_MFHI: w_wd = w_hi_fwd;
          OP_MFLO: w_wd = w_lo_fwd;
          default: w_wd = '0;
        endcase
      end
      T_SHIFT: begin
        if (exe_aluop_i == OP_SLL) begin
          w_wd = exe_src2_i << exe_src1_i[4:0];
        end
      end
      T_JUMP:  w_wd = exe_retaddr_i;
      default: w_wd = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // HI/LO result
  // ---------------------------------------------------------------------------
  logic        w_whilo;
  logic [63:0] w_hilo;

  always_comb begin
    w_whilo = exe_whilo_i;
    w_hilo  = '0;
    if (w_is_div) begin
      // DIV only commits HI/LO in its DONE cycle.
      w_whilo = w_div_done;
      if (w_div_done) begin
        w_hilo = {w_div_hi, w_div_lo};
      end
    end else if (exe_aluop_i == OP_MULT) begin
      w_hilo = w_prod;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all held at 0 while reset is asserted
  // ---------------------------------------------------------------------------
  assign exe_aluop_o  = cpu_rst_n ? exe_aluop_i   : '0;
  assign exe_wa_o     = cpu_rst_n ? exe_wa_i      : '0;
  assign exe_wreg_o   = cpu_rst_n ? exe_wreg_i    : 1'b0;
  assign exe_mreg_o   = cpu_rst_n ? exe_mreg_i    : 1'b0;
  assign exe_din_o    = cpu_rst_n ? exe_din_i     : '0;
  assign exe_wd_o     = cpu_rst_n ? w_wd          : '0;
  assign exe_whilo_o  = cpu_rst_n ? w_whilo       : 1'b0;
  assign exe_hilo_o   = cpu_rst_n ? w_hilo        : '0;
  assign stallreq_exe = cpu_rst_n ? w_div_stall   : 1'b0;

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage : directed and randomized checks of exe_stage against a
// behavioural model written from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_exe_stage;

  localparam logic [2:0] T_ARITH = 3'd1;
  localparam logic [2:0] T_LOGIC = 3'd2;
  localparam logic [2:0] T_MOVE  = 3'd3;
  localparam logic [2:0] T_SHIFT = 3'd4;
  localparam logic [2:0] T_JUMP  = 3'd5;

  localparam logic [7:0] OP_ADD   = 8'h18;
  localparam logic [7:0] OP_ADDIU = 8'h19;
  localparam logic [7:0] OP_SUBU  = 8'h1B;
  localparam logic [7:0] OP_AND   = 8'h1C;
  localparam logic [7:0] OP_ORI   = 8'h1D;
  localparam logic [7:0] OP_SLT   = 8'h26;
  localparam logic [7:0] OP_SLTIU = 8'h27;
  localparam logic [7:0] OP_MULT  = 8'h14;
  localparam logic [7:0] OP_DIV   = 8'h16;
  localparam logic [7:0] OP_MFHI  = 8'h0C;
  localparam logic [7:0] OP_MFLO  = 8'h0D;
  localparam logic [7:0] OP_SLL   = 8'h11;
  localparam logic [7:0] OP_LUI   = 8'h05;
  localparam logic [7:0] OP_LB    = 8'h90;
  localparam logic [7:0] OP_LW    = 8'h92;
  localparam logic [7:0] OP_SB    = 8'h98;
  localparam logic [7:0] OP_SW    = 8'h9A;
  localparam logic [7:0] OP_J     = 8'h2C;
  localparam logic [7:0] OP_JAL   = 8'h2E;
  localparam logic [7:0] OP_JR    = 8'h2D;
  localparam logic [7:0] OP_BEQ   = 8'h30;
  localparam logic [7:0] OP_BNE   = 8'h31;

  // ---------------------------------------------------------------- clock/reset
  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  logic [2:0]  exe_alutype_i;
  logic [7:0]  exe_aluop_i;
  logic [31:0] exe_src1_i, exe_src2_i;
  logic [4:0]  exe_wa_i;
  logic        exe_wreg_i, exe_mreg_i, exe_whilo_i;
  logic [31:0] exe_din_i, exe_retaddr_i, hi_i, lo_i;
  logic        mem2exe_whilo, wb2exe_whilo;
  logic [63:0] mem2exe_hilo, wb2exe_hilo;
  logic [7:0]  exe_aluop_o;
  logic [4:0]  exe_wa_o;
  logic        exe_wreg_o, exe_mreg_o, exe_whilo_o, stallreq_exe;
  logic [31:0] exe_wd_o, exe_din_o;
  logic [63:0] exe_hilo_o;

  exe_stage #(.DIV_CYCLES(32)) dut (
    .cpu_clk_50M   (cpu_clk_50M),
    .cpu_rst_n     (cpu_rst_n),
    .exe_alutype_i (exe_alutype_i),
    .exe_aluop_i   (exe_aluop_i),
    .exe_src1_i    (exe_src1_i),
    .exe_src2_i    (exe_src2_i),
    .exe_wa_i      (exe_wa_i),
    .exe_wreg_i    (exe_wreg_i),
    .exe_mreg_i    (exe_mreg_i),
    .exe_whilo_i   (exe_whilo_i),
    .exe_din_i     (exe_din_i),
    .exe_retaddr_i (exe_retaddr_i),
    .hi_i          (hi_i),
    .lo_i          (lo_i),
    .mem2exe_whilo (mem2exe_whilo),
    .mem2exe_hilo  (mem2exe_hilo),
    .wb2exe_whilo  (wb2exe_whilo),
    .wb2exe_hilo   (wb2exe_hilo),
    .exe_aluop_o   (exe_aluop_o),
    .exe_wa_o      (exe_wa_o),
    .exe_wreg_o    (exe_wreg_o),
    .exe_mreg_o    (exe_mreg_o),
    .exe_wd_o      (exe_wd_o),
    .exe_din_o     (exe_din_o),
    .exe_whilo_o   (exe_whilo_o),
    .exe_hilo_o    (exe_hilo_o),
    .stallreq_exe  (stallreq_exe)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [31:0] model_wd(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] ra, input logic [31:0] hi_v,
                                           input logic [31:0] lo_v);
    int signed sa, sb;
    sa = a;
    sb = b;
    if (t == T_ARITH) begin
      if (op == OP_ADD || op == OP_ADDIU || op == OP_LB || op == OP_LW ||
          op == OP_SB || op == OP_SW) return a + b;
      if (op == OP_SUBU)  return a - b;
      if (op == OP_SLT)   return (sa < sb) ? 32'd1 : 32'd0;
      if (op == OP_SLTIU) return (a < b) ? 32'd1 : 32'd0;
      return 32'd0;
    end
    if (t == T_LOGIC) begin
      if (op == OP_AND) return a & b;
      if (op == OP_ORI) return a | b;
      if (op == OP_LUI) return b;
      return 32'd0;
    end
    if (t == T_MOVE) begin
      if (op == OP_MFHI) return hi_v;
      if (op == OP_MFLO) return lo_v;
      return 32'd0;
    end
    if (t == T_SHIFT && op == OP_SLL) return b << (a % 32);
    if (t == T_JUMP) return ra;
    return 32'd0;
  endfunction

  function automatic logic [63:0] model_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    p  = sa * sb;
    return p;
  endfunction

  // {HI=remainder, LO=quotient}; remainder takes the dividend's sign.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic next_cycle();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic set_op(input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    exe_alutype_i = t;
    exe_aluop_i   = op;
    exe_src1_i    = a;
    exe_src2_i    = b;
  endtask

  // Drives a DIV at posedge+1 (stage in IDLE) and checks every cycle until the
  // result cycle; returns at posedge+1 after the result cycle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n_stall;
    logic [63:0] exp_v;
    set_op(T_ARITH, OP_DIV, a, b);
    exe_whilo_i = 1'b1;
    exp_q.push_back(model_div(a, b));
    n_stall = (b == 32'd0) ? 1 : 33;
    for (int i = 0; i < n_stall; i++) begin
      #3;
      chk({tag, "_stall"}, {63'd0, stallreq_exe}, 64'd1);
      chk({tag, "_busy_hilo"}, {exe_hilo_o[62:0], exe_whilo_o}, 64'd0);
      next_cycle();
    end
    #3;
    exp_v = exp_q.pop_front();
    chk({tag, "_done_stall"}, {63'd0, stallreq_exe}, 64'd0);
    chk({tag, "_done_whilo"}, {63'd0, exe_whilo_o}, 64'd1);
    chk({tag, "_done_hilo"}, exe_hilo_o, exp_v);
    next_cycle();
  endtask

  // ---------------------------------------------------------------- stimulus
  typedef struct packed { logic [2:0] t; logic [7:0] op; } op_t;
  op_t ops[20];

  initial begin
    logic [31:0] a, b, hi_e, lo_e;
    int k;

    ops[0]  = '{T_ARITH, OP_ADD};   ops[1]  = '{T_ARITH, OP_ADDIU};
    ops[2]  = '{T_ARITH, OP_SUBU};  ops[3]  = '{T_ARITH, OP_SLT};
    ops[4]  = '{T_ARITH, OP_SLTIU}; ops[5]  = '{T_ARITH, OP_LB};
    ops[6]  = '{T_ARITH, OP_SW};    ops[7]  = '{T_LOGIC, OP_AND};
    ops[8]  = '{T_LOGIC, OP_ORI};   ops[9]  = '{T_LOGIC, OP_LUI};
    ops[10] = '{T_MOVE,  OP_MFHI};  ops[11] = '{T_MOVE,  OP_MFLO};
    ops[12] = '{T_SHIFT, OP_SLL};   ops[13] = '{T_JUMP,  OP_JAL};
    ops[14] = '{T_JUMP,  OP_BEQ};   ops[15] = '{T_ARITH, OP_MULT};
    ops[16] = '{3'd0,    OP_ADD};   ops[17] = '{3'd7,    OP_AND};
    ops[18] = '{T_ARITH, OP_LW};    ops[19] = '{T_ARITH, OP_SB};

    // Reset with a live DIV and nonzero controls: everything must read 0.
    cpu_rst_n     = 1'b0;
    set_op(T_ARITH, OP_DIV, 32'd40, 32'd3);
    exe_wa_i      = 5'd7;   exe_wreg_i = 1'b1; exe_mreg_i = 1'b1;
    exe_whilo_i   = 1'b1;   exe_din_i  = 32'hDEAD_BEEF;
    exe_retaddr_i = 32'h100; hi_i = 32'h11; lo_i = 32'h22;
    mem2exe_whilo = 1'b0; mem2exe_hilo = '0;
    wb2exe_whilo  = 1'b0; wb2exe_hilo  = '0;
    #4;
    chk("rst_stall", {63'd0, stallreq_exe}, 64'd0);
    chk("rst_wd", {32'd0, exe_wd_o}, 64'd0);
    chk("rst_hilo", exe_hilo_o, 64'd0);
    chk("rst_pass", {exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o, exe_din_o},
        64'd0);
    next_cycle();
    set_op(T_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    exe_whilo_i = 1'b0;
    cpu_rst_n = 1'b1;

    // Directed ALU cases
    #3; chk("add_wrap", {32'd0, exe_wd_o}, 64'h8000_0000);
    chk("add_pass", {exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_din_o},
        {8'h18, 5'd7, 1'b1, 1'b1, 32'hDEAD_BEEF});
    next_cycle();
    set_op(T_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    #3; chk("slt_neg", {32'd0, exe_wd_o}, 64'd1);
    next_cycle();
    set_op(T_ARITH, OP_SLTIU, 32'hFFFF_FFFF, 32'd1);
    #3; chk("sltiu_big", {32'd0, exe_wd_o}, 64'd0);
    next_cycle();
    set_op(T_ARITH, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    exe_whilo_i = 1'b1;
    #3; chk("mult_hilo", exe_hilo_o, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_whilo", {63'd0, exe_whilo_o}, 64'd1);
    chk("mult_stall", {63'd0, stallreq_exe}, 64'd0);
    next_cycle();

    // DIV -7/2, then keep the DIV held: result must not repeat the next cycle.
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2);
    #3; chk("div_once_whilo", {63'd0, exe_whilo_o}, 64'd0);
    chk("div_restart_stall", {63'd0, stallreq_exe}, 64'd1);
    next_cycle();
    // Flush mid-RUN: stall drops in the same cycle and the new op computes.
    set_op(T_ARITH, OP_ADD, 32'd50, 32'd5);
    exe_whilo_i = 1'b0;
    #3; chk("abort_stall", {63'd0, stallreq_exe}, 64'd0);
    chk("abort_wd", {32'd0, exe_wd_o}, 64'd55);
    next_cycle();

    // Divide by zero, then a back-to-back DIV
    run_div("div_5_0", 32'd5, 32'd0);
    run_div("div_100_7", 32'd100, 32'd7);
    run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);

    // HI/LO forwarding priority
    set_op(T_MOVE, OP_MFLO, 32'd0, 32'd0);
    hi_i = 32'hA1; lo_i = 32'd1;
    wb2exe_whilo = 1'b1;  wb2exe_hilo  = {32'hB2, 32'd2};
    mem2exe_whilo = 1'b1; mem2exe_hilo = {32'hC3, 32'd3};
    #3; chk("mflo_mem", {32'd0, exe_wd_o}, 64'd3);
    next_cycle();
    mem2exe_whilo = 1'b0;
    #3; chk("mflo_wb", {32'd0, exe_wd_o}, 64'd2);
    next_cycle();
    wb2exe_whilo = 1'b0;
    #3; chk("mflo_arch", {32'd0, exe_wd_o}, 64'd1);
    next_cycle();
    set_op(T_MOVE, OP_MFHI, 32'd0, 32'd0);
    mem2exe_whilo = 1'b1;
    #3; chk("mfhi_mem", {32'd0, exe_wd_o}, 64'hC3);
    next_cycle();
    mem2exe_whilo = 1'b0;

    // Reset in the middle of a division
    set_op(T_ARITH, OP_DIV, 32'd1000, 32'd3);
    exe_whilo_i = 1'b1;
    for (int i = 0; i < 11; i++) next_cycle();
    #1; chk("mid_run_stall", {63'd0, stallreq_exe}, 64'd1);
    cpu_rst_n = 1'b0;
    #1;
    chk("midrst_stall", {63'd0, stallreq_exe}, 64'd0);
    chk("midrst_out", {exe_hilo_o[62:0], exe_whilo_o}, 64'd0);
    chk("midrst_wd", {32'd0, exe_wd_o}, 64'd0);
    set_op(T_ARITH, OP_DIV, 32'd9, 32'd3);
    next_cycle();
    cpu_rst_n = 1'b1;
    run_div("div_9_3", 32'd9, 32'd3);

    // Randomized single-cycle ops
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 19);
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      set_op(ops[k].t, ops[k].op, a, b);
      exe_wa_i = 5'($urandom); exe_wreg_i = 1'($urandom); exe_mreg_i = 1'($urandom);
      exe_whilo_i = 1'($urandom); exe_din_i = $urandom; exe_retaddr_i = $urandom;
      hi_i = $urandom; lo_i = $urandom;
      mem2exe_whilo = 1'($urandom); mem2exe_hilo = {$urandom, $urandom};
      wb2exe_whilo  = 1'($urandom); wb2exe_hilo  = {$urandom, $urandom};
      hi_e = mem2exe_whilo ? mem2exe_hilo[63:32] : (wb2exe_whilo ? wb2exe_hilo[63:32] : hi_i);
      lo_e = mem2exe_whilo ? mem2exe_hilo[31:0]  : (wb2exe_whilo ? wb2exe_hilo[31:0]  : lo_i);
      #3;
      if (ops[k].op == OP_MULT) begin
        chk("rnd_mult_hilo", exe_hilo_o, model_mult(a, b));
        chk("rnd_mult_whilo", {63'd0, exe_whilo_o}, {63'd0, exe_whilo_i});
      end else begin
        chk("rnd_wd", {32'd0, exe_wd_o},
            {32'd0, model_wd(ops[k].t, ops[k].op, a, b, exe_retaddr_i, hi_e, lo_e)});
      end
      chk("rnd_stall", {63'd0, stallreq_exe}, 64'd0);
      chk("rnd_pass", {exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_din_o},
          {exe_aluop_i, exe_wa_i, exe_wreg_i, exe_mreg_i, exe_din_i});
      next_cycle();
    end

    // Randomized divisions, including sign mixes and zero divisors
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        2: b = 32'd0 - 32'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      run_div("rnd_div", a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound in case anything above stops advancing.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the MiniMIPS32 five-stage pipeline, directly downstream of the decode stage (via the ID/EXE pipeline register).
- Consumes alutype/aluop/operands and produces the write-back value and address/store data; also produces HI/LO updates and forwarding to decode.
- Contains a single-cycle signed multiplier and a multi-cycle radix-2 signed divider; stalls the pipeline through stallreq_exe while a DIV is in progress.

Parameters:
DIV_CYCLES, 32, number of divider iteration cycles (one quotient bit per cycle)

Ports:
cpu_clk_50M  in  1  pipeline clock
cpu_rst_n  in  1  asynchronous reset, active-low
exe_alutype_i  in  3  1=arith, 2=logic, 3=move-from-HILO, 4=shift, 5=jump/branch
exe_aluop_i  in  8  opcode: ADD 0x18, SUBU 0x1B, AND 0x1C, SLT 0x26, MULT 0x14, DIV 0x16, MFHI 0x0C, MFLO 0x0D, SLL 0x11, ADDIU 0x19, ORI 0x1D, SLTIU 0x27, LUI 0x05, LB 0x90, LW 0x92, SB 0x98, SW 0x9A, J 0x2C, JAL 0x2E, JR 0x2D, BEQ 0x30, BNE 0x31
exe_src1_i  in  32  operand 1 (shift amount for SLL)
exe_src2_i  in  32  operand 2 / extended immediate
exe_wa_i  in  5  destination register
exe_wreg_i  in  1  GPR write enable
exe_mreg_i  in  1  result comes from memory
exe_whilo_i  in  1  HILO write enable
exe_din_i  in  32  store data
exe_retaddr_i  in  32  link address (PC+8)
hi_i, lo_i  in  32 each  architectural HI/LO
mem2exe_whilo  in  1  MEM stage writes HILO
mem2exe_hilo  in  64  {HI,LO} value from MEM stage
wb2exe_whilo  in  1  WB stage writes HILO
wb2exe_hilo  in  64  {HI,LO} value from WB stage
exe_aluop_o  out  8  passthrough to MEM
exe_wa_o  out  5  passthrough; also exe2id_wa
exe_wreg_o  out  1  passthrough; also exe2id_wreg
exe_mreg_o  out  1  passthrough; also exe2id_mreg
exe_wd_o  out  32  result / memory address; also exe2id_wd
exe_din_o  out  32  store data passthrough
exe_whilo_o  out  1  HILO write enable to MEM
exe_hilo_o  out  64  {HI,LO} result
stallreq_exe  out  1  stall request to pipeline controller

Behaviour:
- All outputs are combinational from the inputs plus divider state. While cpu_rst_n=0, every output is 0.
- Divider registers (state, dividend/remainder shifter, quotient, divisor, sign flags, counter) reset asynchronously to 0/IDLE.
- exe_wd_o by alutype:
  - arith: ADD/ADDIU = src1+src2, wrapping with no overflow trap; SUBU = src1-src2; SLT = signed(src1<src2); SLTIU = unsigned(src1<src2); loads/stores = src1+src2 (address).
  - logic: AND = src1&src2; ORI = src1|src2; LUI = src2.
  - shift: SLL = src2 << src1[4:0].
  - move: MFHI/MFLO select HI/LO, with forwarding priority mem2exe (if mem2exe_whilo) > wb2exe (if wb2exe_whilo) > hi_i/lo_i.
  - jump/branch: exe_retaddr_i.
  - Any other alutype: 0.
- MULT: exe_hilo_o = signed 64-bit src1*src2, valid in the same cycle; exe_whilo_o = exe_whilo_i.
- DIV FSM (states IDLE, RUN, DONE):
  - IDLE and aluop=DIV with nonzero divisor: latch |src1|, |src2|, quotient sign (sign1^sign2) and remainder sign (sign1); counter=0; go to RUN. stallreq_exe=1.
  - IDLE and aluop=DIV with src2=0: go to DONE; result is LO=0xFFFFFFFF, HI=src1. stallreq_exe=1.
  - RUN: one restoring step per cycle, producing 1 quotient bit. After DIV_CYCLES steps go to DONE. stallreq_exe=1 throughout.
  - DONE: exe_hilo_o = {signed remainder, signed quotient}; exe_whilo_o=1; stallreq_exe=0; next state IDLE.
  - Latency: 34 cycles in EXE; stall high for 33 cycles. Divide-by-zero: 2 cycles, stall high for 1.
  - For DIV, exe_whilo_o and exe_hilo_o are 0 in every state except DONE.
  - aluop!=DIV while in RUN: abort to IDLE, stall deasserts that cycle.
  - Reset asserted mid-division: immediate return to IDLE with no stall.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- Inputs are held stable by the ID/EXE register while stallreq_exe=1. The block does not latch operands other than for division.
- stallreq_exe is 0 for every non-DIV op.

Test Plan:
- ADD src1=0x7FFFFFFF, src2=1 -> exe_wd_o=0x80000000. SLT 0xFFFFFFFF vs 1 -> 1. SLTIU same operands -> 0.
- MULT 0xFFFFFFFE x 3 -> exe_hilo_o=0xFFFFFFFF_FFFFFFFA, exe_whilo_o=1, no stall.
- DIV -7 / 2 held stable -> stallreq_exe high 33 cycles, then DONE cycle: LO=0xFFFFFFFD, HI=0xFFFFFFFF, exe_whilo_o=1 for exactly one cycle.
- DIV 5 / 0 -> stall 1 cycle, then LO=0xFFFFFFFF, HI=5. Back-to-back DIV 100/7 -> LO=14, HI=2.
- MFLO with lo_i=1, wb2exe_hilo lo=2 (whilo=1), mem2exe_hilo lo=3 (whilo=1) -> exe_wd_o=3. Drop mem2exe_whilo -> 2.
- cpu_rst_n pulsed low at RUN cycle 10 -> all outputs 0 immediately; after release, new DIV 9/3 -> LO=3, HI=0 after full latency.
